alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
Pipeline stage directly downstream of the 32-bit ALU built from the alu_top/alu_bottom slices. It registers the ALU result, overflow and carry-out together with destination-register info. It derives the zero flag and buffers one extra entry (2-entry skid) so upstream stalls never drop a result. It also keeps sticky overflow status and a saturating overflow counter for the lab's debug readout.

Parameters:
WIDTH, 32, datapath width of alu_result_i / result_o
RD_W, 5, destination register address width
CNT_W, 8, width of saturating overflow counter

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
in_valid_i  input  1  ALU output is valid this cycle
in_ready_o  output  1  stage can accept an entry this cycle
alu_result_i  input  WIDTH  ALU result bus
alu_overflow_i  input  1  overflow from MSB slice (add/sub/slt ops)
alu_cout_i  input  1  carry-out from MSB slice
rd_addr_i  input  RD_W  destination register
reg_write_i  input  1  write-enable for this instruction
out_valid_o  output  1  output entry valid
out_ready_i  input  1  downstream accepts entry
result_o  output  WIDTH  registered result
zero_o  output  1  1 when registered result == 0
overflow_o  output  1  registered overflow
cout_o  output  1  registered carry-out
rd_addr_o  output  RD_W  registered destination
reg_write_o  output  1  registered write-enable (see Optional Feature)
ovf_sticky_o  output  1  sticky: an overflowed entry has left the stage
ovf_clear_i  input  1  clears ovf_sticky_o and ovf_cnt_o
ovf_cnt_o  output  CNT_W  saturating count of overflowed entries sent out

Behaviour:
- Reset, rst_i high at the clock edge: main_valid=0, skid_valid=0, all data outputs 0, zero_o=0, ovf_sticky_o=0, ovf_cnt_o=0.
- in_ready_o is 0 while rst_i=1. Otherwise in_ready_o = ~skid_valid, decoded from a register.
- Input handshake: accept = in_valid_i & in_ready_o.
- Output handshake: send = out_valid_o & out_ready_i. out_valid_o = main_valid.
- Entry format: {result, zero, overflow, cout, rd_addr, reg_write}. zero is computed at capture time as (alu_result_i == 0).
- Each cycle:
  - If ~main_valid | out_ready_i: main loads the skid entry if skid_valid, else the input entry if accept. main_valid is set from the source used, else 0. skid_valid <= 0.
  - Else, if accept: skid loads the input entry and skid_valid <= 1.
- Latency is 1 cycle, input to out_valid_o, when not stalled. Throughput is 1 entry/cycle with out_ready_i held high.
- Full condition: main and skid both valid. in_ready_o=0 the next cycle, and no entry is lost or overwritten.
- Ordering is strictly FIFO; the skid entry always leaves before any newer input.
- Data outputs hold their value while out_valid_o=1 & out_ready_i=0. After main empties, data outputs keep their last value.
- On a send with that entry's overflow=1: ovf_sticky_o <= 1 and ovf_cnt_o increments, saturating at 2^CNT_W-1 with no wrap.
- ovf_clear_i in the same cycle as an overflowed send: the set/increment wins, giving sticky=1 and cnt=1.
- rst_i asserted mid-stall flushes both entries. Entries presented in the reset cycle are discarded.
- No combinational path from out_ready_i to in_ready_o.

Optional Feature:
- Macro OVF_TRAP_EN.
- Defined:
  - An entry with overflow=1 is captured with reg_write forced to 0, suppressing the writeback as a MIPS add/sub trap.
  - Extra output port exc_o (1 bit) is added. It is high for exactly the send cycle of that entry, and reset value is 0.
- Undefined: reg_write passes through unchanged and exc_o does not exist.

Test Plan:
- Reset then single transfer: rst_i=1 for 2 cycles. Then in_valid_i=1, alu_result_i=32'h0000_0005, rd_addr_i=3, out_ready_i=1. Required next cycle: out_valid_o=1, result_o=5, zero_o=0, rd_addr_o=3; in_ready_o=1 throughout.
- Zero flag: alu_result_i=32'h0 with reg_write_i=1, then the following entry 32'hFFFF_FFFF. Required: zero_o=1, then zero_o=0.
- Backpressure and skid: out_ready_i=0 while entries A=1, B=2, C=3 are offered back-to-back. Required: A held at the output, B in the skid, in_ready_o=0 and C held upstream. Releasing out_ready_i=1 yields outputs 1,2,3 in order with no duplicates.
- Overflow tracking: send 3 entries with alu_overflow_i=1 (e.g. 32'h7FFF_FFFF + 1). Required: ovf_sticky_o=1, ovf_cnt_o=3. ovf_clear_i asserted in the same cycle as a 4th overflowed send gives ovf_cnt_o=1 and sticky=1.
- Counter saturation with CNT_W=2: 5 overflowed sends. Required: ovf_cnt_o stays at 3.
- Mid-stall reset with OVF_TRAP_EN defined: stage full, rst_i=1 for one cycle. Required: out_valid_o=0 and in_ready_o=1 the cycle after. Then an overflowed entry with reg_write_i=1 produces reg_write_o=0 and exc_o=1 for exactly one cycle.

Source files
------------

// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//
// Pipeline register directly after the 32-bit ALU. Each accepted ALU result is
// captured together with its flags and writeback info into a two-entry skid
// buffer (main + skid), so an upstream producer that only sees a registered
// ready never loses a result when downstream stalls. The stage also keeps a
// sticky overflow bit and a saturating count of overflowed entries sent out,
// for debug readout.
//
// Handshake (both sides): a transfer happens on a rising clk_i edge when valid
// and ready are both high. valid must not depend on ready. in_ready_o is a
// function of rst_i and registered state only, never of out_ready_i.
//
// Optional feature, macro OVF_TRAP_EN:
//   defined   - an overflowed entry is captured with reg_write forced to 0
//               (MIPS add/sub trap) and exc_o pulses for that entry's send cycle
//   undefined - reg_write passes through unchanged; exc_o does not exist
//
// Ports:
//   clk_i, rst_i         clock; synchronous active-high reset
//   in_valid_i/in_ready_o  upstream handshake
//   alu_result_i         ALU result bus (WIDTH)
//   alu_overflow_i       overflow from the MSB slice
//   alu_cout_i           carry-out from the MSB slice
//   rd_addr_i            destination register (RD_W)
//   reg_write_i          writeback enable
//   out_valid_o/out_ready_i downstream handshake
//   result_o, zero_o, overflow_o, cout_o, rd_addr_o, reg_write_o
//                        registered entry at the head of the stage
//   exc_o                (OVF_TRAP_EN only) overflow trap, send cycle only
//   ovf_sticky_o         set once an overflowed entry has been sent
//   ovf_clear_i          clears ovf_sticky_o and ovf_cnt_o
//   ovf_cnt_o            saturating count of overflowed entries sent (CNT_W)
// -----------------------------------------------------------------------------
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    // upstream
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_overflow_i,
    input  logic             alu_cout_i,
    input  logic [RD_W-1:0]  rd_addr_i,
    input  logic             reg_write_i,
    // downstream
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             cout_o,
    output logic [RD_W-1:0]  rd_addr_o,
    output logic             reg_write_o,
`ifdef OVF_TRAP_EN
    output logic             exc_o,
`endif
    // overflow debug status
    output logic             ovf_sticky_o,
    input  logic             ovf_clear_i,
    output logic [CNT_W-1:0] ovf_cnt_o
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             overflow;
        logic             cout;
        logic [RD_W-1:0]  rd_addr;
        logic             reg_write;
    } entry_t;

    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    entry_t           in_entry;
    logic             accept;
    logic             send;

    // ------------------------------------------------------------------
    // Entry formatting at capture time
    // ------------------------------------------------------------------
    always_comb begin
        in_entry           = '0;
        in_entry.result    = alu_result_i;
        in_entry.zero      = (alu_result_i == '0);
        in_entry.overflow  = alu_overflow_i;
        in_entry.cout      = alu_cout_i;
        in_entry.rd_addr   = rd_addr_i;
`ifdef OVF_TRAP_EN
        // Trapping add/sub must not commit its result to the register file.
        in_entry.reg_write = reg_write_i & ~alu_overflow_i;
`else
        in_entry.reg_write = reg_write_i;
`endif
    end

    // ------------------------------------------------------------------
    // Handshakes. Ready comes from the skid flag only, so a stalled
    // downstream cannot ripple combinationally into the producer.
    // ------------------------------------------------------------------
    assign in_ready_o  = ~rst_i & ~skid_valid_q;
    assign accept      = in_valid_i & in_ready_o;
    assign out_valid_o = main_valid_q;
    assign send        = main_valid_q & out_ready_i;

    // ------------------------------------------------------------------
    // Main / skid next state
    // ------------------------------------------------------------------
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (~main_valid_q | out_ready_i) begin
            // Main is free this cycle. The skid entry is older than anything
            // on the input, so it always goes first. When the skid is full
            // in_ready_o is low, so accept cannot also be high.
            skid_valid_d = 1'b0;
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
            end else if (accept) begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end else begin
                // Data fields keep their last value; only valid drops.
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Main is stalled; park the new entry in the skid slot.
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Overflow status. Clear is applied first so a same-cycle overflowed
    // send restarts the count at 1 and leaves sticky set.
    // ------------------------------------------------------------------
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        ovf_cnt_d    = ovf_cnt_q;

        if (ovf_clear_i) begin
            ovf_sticky_d = 1'b0;
            ovf_cnt_d    = '0;
        end

        if (send & main_q.overflow) begin
            ovf_sticky_d = 1'b1;
            if (ovf_cnt_d != {CNT_W{1'b1}}) begin
                ovf_cnt_d = ovf_cnt_d + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ovf_sticky_q <= 1'b0;
            ovf_cnt_q    <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ovf_sticky_q <= ovf_sticky_d;
            ovf_cnt_q    <= ovf_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign result_o     = main_q.result;
    assign zero_o       = main_q.zero;
    assign overflow_o   = main_q.overflow;
    assign cout_o       = main_q.cout;
    assign rd_addr_o    = main_q.rd_addr;
    assign reg_write_o  = main_q.reg_write;
    assign ovf_sticky_o = ovf_sticky_q;
    assign ovf_cnt_o    = ovf_cnt_q;

`ifdef OVF_TRAP_EN
    // Pulses only in the cycle the trapping entry actually leaves the stage.
    assign exc_o = send & main_q.overflow;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// -----------------------------------------------------------------------------
// Directed bench for alu_result_stage. Two instances share all inputs: the
// default one (CNT_W=8) and one with CNT_W=2 to observe counter saturation.
// Inputs are driven 1 ns after the rising edge; outputs are checked 1 ns
// later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_alu_result_stage;

    localparam int WIDTH = 32;
    localparam int RD_W  = 5;

`ifdef OVF_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // shared stimulus
    logic             in_valid;
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;
    logic             alu_cout;
    logic [RD_W-1:0]  rd_addr;
    logic             reg_write;
    logic             out_ready;
    logic             ovf_clear;

    // main instance outputs
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             cout;
    logic [RD_W-1:0]  rd_out;
    logic             rw_out;
    logic             sticky;
    logic [7:0]       cnt;
`ifdef OVF_TRAP_EN
    logic             exc;
    logic             s_exc;
`endif

    // saturation instance outputs
    logic             s_in_ready;
    logic             s_out_valid;
    logic [WIDTH-1:0] s_result;
    logic             s_zero;
    logic             s_overflow;
    logic             s_cout;
    logic [RD_W-1:0]  s_rd_out;
    logic             s_rw_out;
    logic             s_sticky;
    logic [1:0]       s_cnt;

    alu_result_stage #(.WIDTH(WIDTH), .RD_W(RD_W), .CNT_W(8)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .alu_result_i   (alu_result),
        .alu_overflow_i (alu_overflow),
        .alu_cout_i     (alu_cout),
        .rd_addr_i      (rd_addr),
        .reg_write_i    (reg_write),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .result_o       (result),
        .zero_o         (zero),
        .overflow_o     (overflow),
        .cout_o         (cout),
        .rd_addr_o      (rd_out),
        .reg_write_o    (rw_out),
`ifdef OVF_TRAP_EN
        .exc_o          (exc),
`endif
        .ovf_sticky_o   (sticky),
        .ovf_clear_i    (ovf_clear),
        .ovf_cnt_o      (cnt)
    );

    alu_result_stage #(.WIDTH(WIDTH), .RD_W(RD_W), .CNT_W(2)) dut_sat (
        .clk_i          (clk),
        .rst_i          (rst),
        .in_valid_i     (in_valid),
        .in_ready_o     (s_in_ready),
        .alu_result_i   (alu_result),
        .alu_overflow_i (alu_overflow),
        .alu_cout_i     (alu_cout),
        .rd_addr_i      (rd_addr),
        .reg_write_i    (reg_write),
        .out_valid_o    (s_out_valid),
        .out_ready_i    (out_ready),
        .result_o       (s_result),
        .zero_o         (s_zero),
        .overflow_o     (s_overflow),
        .cout_o         (s_cout),
        .rd_addr_o      (s_rd_out),
        .reg_write_o    (s_rw_out),
`ifdef OVF_TRAP_EN
        .exc_o          (s_exc),
`endif
        .ovf_sticky_o   (s_sticky),
        .ovf_clear_i    (ovf_clear),
        .ovf_cnt_o      (s_cnt)
    );

    // scoreboard counters
    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] r, input logic [RD_W-1:0] rd,
                         input logic ovf, input logic co, input logic rw);
        in_valid     = v;
        alu_result   = r;
        rd_addr      = rd;
        alu_overflow = ovf;
        alu_cout     = co;
        reg_write    = rw;
    endtask

    // expected reg_write_o for an overflowed entry captured with reg_write_i=1
    logic exp_rw_ovf;

    initial begin
        exp_rw_ovf = ~TRAP_EN;
        rst        = 1'b1;
        out_ready  = 1'b0;
        ovf_clear  = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // ---------------- reset ----------------
        tick();
        tick();
        settle();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_zero", zero, 0);
        check_eq("rst_sticky", sticky, 0);
        check_eq("rst_cnt", cnt, 0);

        // ---------------- single transfer ----------------
        rst       = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_0005, 5'd3, 1'b0, 1'b0, 1'b1);
        settle();
        check_eq("xfer_in_ready_pre", in_ready, 1);
        tick();
        settle();
        check_eq("xfer_out_valid", out_valid, 1);
        check_eq("xfer_result", result, 32'h5);
        check_eq("xfer_zero", zero, 0);
        check_eq("xfer_rd", rd_out, 3);
        check_eq("xfer_rw", rw_out, 1);
        check_eq("xfer_in_ready", in_ready, 1);
`ifdef OVF_TRAP_EN
        check_eq("xfer_exc", exc, 0);
`endif

        // ---------------- zero flag ----------------
        drive(1'b1, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1);
        tick();
        settle();
        check_eq("zero_result", result, 0);
        check_eq("zero_flag_set", zero, 1);
        check_eq("zero_rd", rd_out, 4);
        drive(1'b1, 32'hFFFF_FFFF, 5'd5, 1'b0, 1'b1, 1'b0);
        tick();
        settle();
        check_eq("ones_result", result, 32'hFFFF_FFFF);
        check_eq("ones_zero", zero, 0);
        check_eq("ones_cout", cout, 1);
        check_eq("ones_rw", rw_out, 0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        settle();
        check_eq("empty_out_valid", out_valid, 0);
        check_eq("empty_hold_result", result, 32'hFFFF_FFFF);
        check_eq("no_ovf_cnt", cnt, 0);
        check_eq("no_ovf_sticky", sticky, 0);

        // ---------------- backpressure / skid ----------------
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 5'd1, 1'b0, 1'b0, 1'b1);
        tick();
        settle();
        check_eq("bp_a_valid", out_valid, 1);
        check_eq("bp_a_result", result, 1);
        check_eq("bp_a_in_ready", in_ready, 1);
        drive(1'b1, 32'd2, 5'd2, 1'b0, 1'b0, 1'b1);
        tick();
        settle();
        check_eq("bp_b_hold_a", result, 1);
        check_eq("bp_full_in_ready", in_ready, 0);
        drive(1'b1, 32'd3, 5'd3, 1'b0, 1'b0, 1'b1);
        tick();
        settle();
        check_eq("bp_c_hold_a", result, 1);
        check_eq("bp_c_hold_rd", rd_out, 1);
        check_eq("bp_c_in_ready", in_ready, 0);
        check_eq("bp_c_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        settle();
        check_eq("bp_out_b", result, 2);
        check_eq("bp_out_b_rd", rd_out, 2);
        check_eq("bp_b_in_ready", in_ready, 1);
        tick();
        settle();
        check_eq("bp_out_c", result, 3);
        check_eq("bp_out_c_rd", rd_out, 3);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        settle();
        check_eq("bp_drained", out_valid, 0);

        // ---------------- overflow tracking ----------------
        drive(1'b1, 32'h8000_0000, 5'd7, 1'b1, 1'b0, 1'b1);
        tick();
        settle();
        check_eq("ovf1_out_overflow", overflow, 1);
        check_eq("ovf1_rw", rw_out, exp_rw_ovf);
        check_eq("ovf1_sticky_unsent", sticky, 0);
        check_eq("ovf1_cnt_unsent", cnt, 0);
`ifdef OVF_TRAP_EN
        check_eq("ovf1_exc", exc, 1);
`endif
        tick();
        settle();
        check_eq("ovf_cnt_1", cnt, 1);
        check_eq("ovf_sticky_1", sticky, 1);
        tick();
        settle();
        check_eq("ovf_cnt_2", cnt, 2);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        settle();
        check_eq("ovf_cnt_3", cnt, 3);
        check_eq("ovf_sticky_3", sticky, 1);
        check_eq("sat_cnt_3", s_cnt, 3);

        // 4th overflowed send together with clear
        drive(1'b1, 32'h8000_0000, 5'd8, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        ovf_clear = 1'b1;
        tick();
        settle();
        check_eq("clr_send_cnt", cnt, 1);
        check_eq("clr_send_sticky", sticky, 1);
        check_eq("clr_send_sat_cnt", s_cnt, 1);
        tick();
        settle();
        check_eq("clr_cnt", cnt, 0);
        check_eq("clr_sticky", sticky, 0);
        ovf_clear = 1'b0;

        // ---------------- saturation (CNT_W=2 instance) ----------------
        drive(1'b1, 32'h8000_0000, 5'd9, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            check_eq($sformatf("sat_loop_cnt_%0d", i), cnt, i);
            check_eq($sformatf("sat_loop_scnt_%0d", i), s_cnt, (i > 3) ? 3 : i);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        settle();
        check_eq("sat_final_cnt", cnt, 5);
        check_eq("sat_final_scnt", s_cnt, 3);
        check_eq("sat_final_ssticky", s_sticky, 1);

        // ---------------- mid-stall reset ----------------
        out_ready = 1'b0;
        drive(1'b1, 32'hA1, 5'd10, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'hA2, 5'd11, 1'b0, 1'b0, 1'b1);
        tick();
        settle();
        check_eq("mid_full_in_ready", in_ready, 0);
        check_eq("mid_full_valid", out_valid, 1);
        rst = 1'b1;
        drive(1'b1, 32'hA3, 5'd12, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        settle();
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_in_ready", in_ready, 1);
        check_eq("mid_rst_result", result, 0);
        check_eq("mid_rst_cnt", cnt, 0);
        check_eq("mid_rst_sticky", sticky, 0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        settle();
        check_eq("mid_rst_skid_flushed", out_valid, 0);

        // ---------------- trap behaviour ----------------
        drive(1'b1, 32'h8000_0000, 5'd13, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        settle();
        check_eq("trap_valid", out_valid, 1);
        check_eq("trap_overflow", overflow, 1);
        check_eq("trap_rw", rw_out, exp_rw_ovf);
`ifdef OVF_TRAP_EN
        check_eq("trap_exc_high", exc, 1);
`endif
        tick();
        settle();
        check_eq("trap_after_valid", out_valid, 0);
        check_eq("trap_after_cnt", cnt, 1);
`ifdef OVF_TRAP_EN
        check_eq("trap_exc_low", exc, 0);
`endif
        drive(1'b1, 32'd6, 5'd14, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        settle();
        check_eq("nontrap_rw", rw_out, 1);
        check_eq("nontrap_result", result, 6);
`ifdef OVF_TRAP_EN
        check_eq("nontrap_exc", exc, 0);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
